// File: rtl/stream_packer_if.sv
// Stream packer handshake bundle: narrow input stream, wide output stream.
// The flush signal exists only when STREAM_PACKER_FLUSH_EN is defined.
interface stream_packer_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned RATIO      = 4
);
  localparam int unsigned OUT_W = DATA_WIDTH * RATIO;

  logic [DATA_WIDTH-1:0] in_data;
  logic                  in_valid;
  logic                  in_ready;
  logic [OUT_W-1:0]      out_data;
  logic                  out_valid;
  logic                  out_ready;
`ifdef STREAM_PACKER_FLUSH_EN
  logic                  flush;

  // Packer side
  modport slave (
    input  in_data, in_valid, out_ready, flush,
    output in_ready, out_data, out_valid
  );

  // Producer/consumer side
  modport master (
    output in_data, in_valid, out_ready, flush,
    input  in_ready, out_data, out_valid
  );
`else
  // Packer side
  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_data, out_valid
  );

  // Producer/consumer side
  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_data, out_valid
  );
`endif
endinterface

// File: rtl/stream_packer.sv
// Narrow-to-wide stream packer: gathers RATIO words into one little-endian
// wide word with a registered output. Optional partial-word flush is enabled
// by defining STREAM_PACKER_FLUSH_EN.
module stream_packer #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned RATIO      = 4
) (
  input  logic           aclk,
  input  logic           aresetn,
  stream_packer_if.slave bus
);
  localparam int unsigned OUT_W = DATA_WIDTH * RATIO;
  localparam int unsigned CNT_W = $clog2(RATIO);
  localparam logic [CNT_W-1:0] LAST_LANE = CNT_W'(RATIO - 1);

  logic [CNT_W-1:0] cnt;
  logic [OUT_W-1:0] acc;
  logic [OUT_W-1:0] acc_wr;
  logic [OUT_W-1:0] out_data_q;
  logic             out_valid_q;

  logic slot_free;
  logic last_lane;
  logic in_ready_c;
  logic in_hs;
  logic out_hs;
  logic complete;
  logic flush_ev;
  logic emit;

  // Handshake qualification; the last lane stalls only behind a held word
  always_comb begin
    slot_free  = ~out_valid_q | bus.out_ready;
    last_lane  = (cnt == LAST_LANE);
    in_ready_c = ~last_lane | slot_free;
    in_hs      = bus.in_valid & in_ready_c;
    out_hs     = out_valid_q & bus.out_ready;
    complete   = in_hs & last_lane;
`ifdef STREAM_PACKER_FLUSH_EN
    flush_ev   = bus.flush & slot_free & ((cnt != '0) | in_hs);
`else
    flush_ev   = 1'b0;
`endif
    emit       = complete | flush_ev;
  end

  // Accumulator view including this cycle's accepted word
  always_comb begin
    acc_wr = acc;
    for (int unsigned k = 0; k < RATIO; k++) begin
      if (in_hs && (cnt == CNT_W'(k))) begin
        acc_wr[k*DATA_WIDTH +: DATA_WIDTH] = bus.in_data;
      end
    end
  end

  // Lane counter, accumulator and registered output word
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      cnt         <= '0;
      acc         <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
    end else if (emit) begin
      out_data_q  <= acc_wr;
      out_valid_q <= 1'b1;
      cnt         <= '0;
      acc         <= '0;
    end else begin
      if (in_hs) begin
        acc <= acc_wr;
        cnt <= cnt + CNT_W'(1);
      end
      if (out_hs) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.out_data  = out_data_q;
  assign bus.out_valid = out_valid_q;

endmodule

// File: tb/tb_stream_packer.sv
// Directed bench for stream_packer (DATA_WIDTH=32, RATIO=4).
// Flush scenarios run when STREAM_PACKER_FLUSH_EN is defined.
module tb_stream_packer;
  localparam int unsigned DW = 32;
  localparam int unsigned RT = 4;

  logic clk;
  logic rst_n;
  int   total;
  int   passed;

  stream_packer_if #(.DATA_WIDTH(DW), .RATIO(RT)) bus ();

  stream_packer #(.DATA_WIDTH(DW), .RATIO(RT)) dut (
    .aclk    (clk),
    .aresetn (rst_n),
    .bus     (bus.slave)
  );

  // 10-unit clock, rising edges at 5, 15, 25, ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic set_in(input logic v, input logic [31:0] d, input logic r);
    bus.in_valid  = v;
    bus.in_data   = d;
    bus.out_ready = r;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    total  = 0;
    passed = 0;
    rst_n  = 1'b0;
    set_in(1'b0, 32'h0, 1'b0);
`ifdef STREAM_PACKER_FLUSH_EN
    bus.flush = 1'b0;
`endif

    // Reset state
    #12;
    chk("rst_out_valid", 128'(bus.out_valid), 128'd0);
    chk("rst_out_data",  bus.out_data,        128'd0);
    chk("rst_in_ready",  128'(bus.in_ready),  128'd1);
    rst_n = 1'b1;
    tick();

    // Single group 0x11..0x44
    set_in(1'b1, 32'h11, 1'b1); settle();
    chk("g1_in_ready0", 128'(bus.in_ready), 128'd1);
    tick();
    set_in(1'b1, 32'h22, 1'b1); tick();
    set_in(1'b1, 32'h33, 1'b1); tick();
    set_in(1'b1, 32'h44, 1'b1); settle();
    chk("g1_in_ready3", 128'(bus.in_ready), 128'd1);
    chk("g1_no_early",  128'(bus.out_valid), 128'd0);
    tick();
    set_in(1'b0, 32'h0, 1'b1); settle();
    chk("g1_valid", 128'(bus.out_valid), 128'd1);
    chk("g1_data",  bus.out_data, 128'h00000044_00000033_00000022_00000011);
    tick();
    chk("g1_drop", 128'(bus.out_valid), 128'd0);

    // Continuous words 1..8 at full rate
    for (int i = 1; i <= 8; i++) begin
      set_in(1'b1, 32'(i), 1'b1); settle();
      chk("c8_in_ready", 128'(bus.in_ready), 128'd1);
      if (i == 5) begin
        chk("c8_v1",  128'(bus.out_valid), 128'd1);
        chk("c8_d1",  bus.out_data, 128'h00000004_00000003_00000002_00000001);
      end else if (i > 5) begin
        chk("c8_gap", 128'(bus.out_valid), 128'd0);
      end
      tick();
    end
    set_in(1'b0, 32'h0, 1'b1); settle();
    chk("c8_v2", 128'(bus.out_valid), 128'd1);
    chk("c8_d2", bus.out_data, 128'h00000008_00000007_00000006_00000005);
    tick();
    chk("c8_drop", 128'(bus.out_valid), 128'd0);

    // Back-pressure on the last lane, then same-cycle handoff
    for (int i = 1; i <= 4; i++) begin
      set_in(1'b1, 32'(i), 1'b1); tick();
    end
    for (int i = 5; i <= 7; i++) begin
      set_in(1'b1, 32'(i), 1'b0); settle();
      chk("bp_low_ready", 128'(bus.in_ready), 128'd1);
      tick();
    end
    set_in(1'b1, 32'h8, 1'b0); settle();
    chk("bp_stall",      128'(bus.in_ready), 128'd0);
    chk("bp_hold_valid", 128'(bus.out_valid), 128'd1);
    chk("bp_hold_data",  bus.out_data, 128'h00000004_00000003_00000002_00000001);
    tick();
    chk("bp_stall2",     128'(bus.in_ready), 128'd0);
    chk("bp_hold_data2", bus.out_data, 128'h00000004_00000003_00000002_00000001);
    set_in(1'b1, 32'h8, 1'b1); settle();
    chk("bp_release", 128'(bus.in_ready), 128'd1);
    tick();
    set_in(1'b0, 32'h0, 1'b1); settle();
    chk("bp_b2b_valid", 128'(bus.out_valid), 128'd1);
    chk("bp_b2b_data",  bus.out_data, 128'h00000008_00000007_00000006_00000005);
    tick();
    chk("bp_drop", 128'(bus.out_valid), 128'd0);

    // Asynchronous reset with two lanes filled
    set_in(1'b1, 32'h99, 1'b1); tick();
    set_in(1'b1, 32'h98, 1'b1); tick();
    set_in(1'b0, 32'h0, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_out_valid", 128'(bus.out_valid), 128'd0);
    chk("ar_in_ready",  128'(bus.in_ready),  128'd1);
    #2 rst_n = 1'b1;
    tick();
    set_in(1'b1, 32'hA, 1'b1); tick();
    set_in(1'b1, 32'hB, 1'b1); tick();
    set_in(1'b1, 32'hC, 1'b1); settle();
    chk("ar_no_stale", 128'(bus.out_valid), 128'd0);
    tick();
    set_in(1'b1, 32'hD, 1'b1); tick();
    set_in(1'b0, 32'h0, 1'b1); settle();
    chk("ar_valid", 128'(bus.out_valid), 128'd1);
    chk("ar_data",  bus.out_data, 128'h0000000D_0000000C_0000000B_0000000A);
    tick();

`ifdef STREAM_PACKER_FLUSH_EN
    // Flush after two lanes
    set_in(1'b1, 32'h5, 1'b1); tick();
    set_in(1'b1, 32'h6, 1'b1); tick();
    set_in(1'b0, 32'h0, 1'b1);
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0; settle();
    chk("fl_valid", 128'(bus.out_valid), 128'd1);
    chk("fl_data",  bus.out_data, 128'h00000000_00000000_00000006_00000005);
    tick();
    chk("fl_drop", 128'(bus.out_valid), 128'd0);

    // Flush on an empty accumulator is ignored
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0; settle();
    chk("fl_empty", 128'(bus.out_valid), 128'd0);
    tick();

    // Flush together with the third word
    set_in(1'b1, 32'h5, 1'b1); tick();
    set_in(1'b1, 32'h6, 1'b1); tick();
    set_in(1'b1, 32'h7, 1'b1);
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    set_in(1'b0, 32'h0, 1'b1); settle();
    chk("fl3_valid", 128'(bus.out_valid), 128'd1);
    chk("fl3_data",  bus.out_data, 128'h00000000_00000007_00000006_00000005);
    tick();

    // Counter restarted at lane 0 after flush
    for (int i = 1; i <= 4; i++) begin
      set_in(1'b1, 32'(i + 32'h20), 1'b1); tick();
    end
    set_in(1'b0, 32'h0, 1'b1); settle();
    chk("fl_realign", bus.out_data, 128'h00000024_00000023_00000022_00000021);
    tick();
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
